bf16_mul_prenorm: RTL and testbench

- Sequential BF16 multiplier front-end that sits directly upstream of the BF16 normalizer in the PE datapath.
- Accepts two BF16 operands over a valid/ready handshake and forms the product sign, biased exponent sum and raw 8x8 significand product with an iterative shift-add multiplier.
- Presents {sign, exp_out, mant_raw} on a registered valid/ready output that feeds the normalizer's sign/exp_in/mant_raw inputs unchanged.

---
 rtl/bf16_mul_prenorm.sv | 172 +++++++++++++++++
 tb/tb_bf16_mul_prenorm.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/bf16_mul_prenorm.sv
// BF16 multiplier front-end: sign, biased exponent sum and raw significand product via iterative shift-add.
// Optional macro PRENORM_SPECIAL_BYPASS_EN lets special operands skip the shift-add iterations.
module bf16_mul_prenorm #(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a_in,
  input  logic [15:0] b_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        sign_out,
  output logic [8:0]  exp_out,
  output logic [15:0] mant_raw
);

  localparam int N = 8 / BITS_PER_CYCLE;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_HOLD} state_t;
  typedef enum logic [1:0] {C_NORM, C_ZERO, C_INF, C_OVF} cls_t;

  function automatic cls_t classify(input logic [7:0] ea, input logic [7:0] eb,
                                    input logic signed [9:0] esum);
    if (ea == 8'hFF || eb == 8'hFF)   return C_INF;
    else if (ea == 8'h00 || eb == 8'h00) return C_ZERO;
    else if (esum <= 10'sd0)          return C_ZERO;
    else if (esum >= 10'sd256)        return C_OVF;
    else                              return C_NORM;
  endfunction

  function automatic logic [8:0] sat_exp(input cls_t c, input logic signed [9:0] esum);
    case (c)
      C_INF:   return 9'h0FF;
      C_ZERO:  return 9'h000;
      C_OVF:   return 9'h100;
      default: return esum[8:0];
    endcase
  endfunction

  function automatic logic [15:0] sat_mant(input cls_t c, input logic [15:0] prod);
    case (c)
      C_INF:   return 16'h4000;
      C_ZERO:  return 16'h0000;
      default: return prod;
    endcase
  endfunction

  state_t            state_q, state_d;
  cls_t              cls_q, cls_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [15:0]       acc_q, acc_d;
  logic [15:0]       mcand_q, mcand_d;
  logic [7:0]        mplier_q, mplier_d;
  logic              sign_q, sign_d;
  logic signed [9:0] esum_q, esum_d;
  logic              out_valid_q, out_valid_d;
  logic              sign_out_q, sign_out_d;
  logic [8:0]        exp_out_q, exp_out_d;
  logic [15:0]       mant_raw_q, mant_raw_d;

  logic signed [9:0] esum_in;
  cls_t              cls_in;
  logic [15:0]       pp;
  logic [15:0]       acc_sum;

  assign esum_in = $signed({2'b00, a_in[14:7]}) + $signed({2'b00, b_in[14:7]}) - 10'sd127;
  assign cls_in  = classify(a_in[14:7], b_in[14:7], esum_in);

  always_comb begin
    state_d     = state_q;
    cls_d       = cls_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    sign_d      = sign_q;
    esum_d      = esum_q;
    out_valid_d = out_valid_q;
    sign_out_d  = sign_out_q;
    exp_out_d   = exp_out_q;
    mant_raw_d  = mant_raw_q;

    // Partial product for the multiplier bits retired this cycle, LSB first
    pp = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (mplier_q[i]) pp = pp + (mcand_q << i);
    end
    acc_sum = acc_q + pp;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          sign_d   = a_in[15] ^ b_in[15];
          cls_d    = cls_in;
          esum_d   = esum_in;
          mcand_d  = {8'h00, 1'b1, a_in[6:0]};
          mplier_d = {1'b1, b_in[6:0]};
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = S_CALC;
`ifdef PRENORM_SPECIAL_BYPASS_EN
          // Specials take a single CALC edge: product formed up front, no bits left to retire
          if (cls_in != C_NORM) begin
            acc_d    = {8'h00, 1'b1, a_in[6:0]} * {8'h00, 1'b1, b_in[6:0]};
            mplier_d = '0;
            cnt_d    = 3'(N - 1);
          end
`endif
        end
      end
      S_CALC: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << BITS_PER_CYCLE;
        mplier_d = mplier_q >> BITS_PER_CYCLE;
        cnt_d    = cnt_q + 3'd1;
        if (cnt_q == 3'(N - 1)) begin
          out_valid_d = 1'b1;
          sign_out_d  = sign_q;
          exp_out_d   = sat_exp(cls_q, esum_q);
          mant_raw_d  = sat_mant(cls_q, acc_sum);
          state_d     = S_HOLD;
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cls_q       <= C_NORM;
      cnt_q       <= '0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      sign_q      <= 1'b0;
      esum_q      <= '0;
      out_valid_q <= 1'b0;
      sign_out_q  <= 1'b0;
      exp_out_q   <= '0;
      mant_raw_q  <= '0;
    end else begin
      state_q     <= state_d;
      cls_q       <= cls_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      sign_q      <= sign_d;
      esum_q      <= esum_d;
      out_valid_q <= out_valid_d;
      sign_out_q  <= sign_out_d;
      exp_out_q   <= exp_out_d;
      mant_raw_q  <= mant_raw_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = out_valid_q;
  assign sign_out  = sign_out_q;
  assign exp_out   = exp_out_q;
  assign mant_raw  = mant_raw_q;

endmodule

// File: tb/tb_bf16_mul_prenorm.sv
// Directed bench for bf16_mul_prenorm: table of vectors on BITS_PER_CYCLE=1 and =4 instances,
// plus backpressure and mid-operation reset sequences.
module tb_bf16_mul_prenorm;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sign;
    logic [8:0]  expo;
    logic [15:0] mant;
    logic        special;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] a_in = '0;
  logic [15:0] b_in = '0;

  logic        in_ready1, out_valid1, sign1;
  logic [8:0]  exp1;
  logic [15:0] mant1;
  logic        in_ready4, out_valid4, sign4;
  logic [8:0]  exp4;
  logic [15:0] mant4;

  int n_chk = 0;
  int n_fail = 0;
  vec_t tbl[16];

  bf16_mul_prenorm #(.BITS_PER_CYCLE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .a_in(a_in), .b_in(b_in), .out_valid(out_valid1), .out_ready(out_ready),
    .sign_out(sign1), .exp_out(exp1), .mant_raw(mant1));

  bf16_mul_prenorm #(.BITS_PER_CYCLE(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
    .a_in(a_in), .b_in(b_in), .out_valid(out_valid4), .out_ready(out_ready),
    .sign_out(sign4), .exp_out(exp4), .mant_raw(mant4));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int lat1, lat4, exp_lat1, exp_lat4;
    lat1 = 0;
    lat4 = 0;
    exp_lat1 = 8;
    exp_lat4 = 2;
`ifdef PRENORM_SPECIAL_BYPASS_EN
    if (v.special) begin
      exp_lat1 = 1;
      exp_lat4 = 1;
    end
`endif
    @(negedge clk);
    chk($sformatf("v%0d_in_ready1", idx), 32'(in_ready1), 32'd1);
    chk($sformatf("v%0d_in_ready4", idx), 32'(in_ready4), 32'd1);
    a_in = v.a;
    b_in = v.b;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      if (out_valid1 && lat1 == 0) lat1 = c;
      if (out_valid4 && lat4 == 0) lat4 = c;
      if (lat1 != 0 && lat4 != 0) break;
    end
    chk($sformatf("v%0d_lat1", idx), 32'(lat1), 32'(exp_lat1));
    chk($sformatf("v%0d_lat4", idx), 32'(lat4), 32'(exp_lat4));
    chk($sformatf("v%0d_sign1", idx), 32'(sign1), 32'(v.sign));
    chk($sformatf("v%0d_exp1", idx), 32'(exp1), 32'(v.expo));
    chk($sformatf("v%0d_mant1", idx), 32'(mant1), 32'(v.mant));
    chk($sformatf("v%0d_sign4", idx), 32'(sign4), 32'(v.sign));
    chk($sformatf("v%0d_exp4", idx), 32'(exp4), 32'(v.expo));
    chk($sformatf("v%0d_mant4", idx), 32'(mant4), 32'(v.mant));
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk($sformatf("v%0d_drain1", idx), 32'(out_valid1), 32'd0);
    chk($sformatf("v%0d_drain4", idx), 32'(out_valid4), 32'd0);
    out_ready = 1'b0;
  endtask

  initial begin
    tbl[0]  = '{16'h3F80, 16'h3F80, 1'b0, 9'h07F, 16'h4000, 1'b0};
    tbl[1]  = '{16'h3FC0, 16'h3FC0, 1'b0, 9'h07F, 16'h9000, 1'b0};
    tbl[2]  = '{16'hC000, 16'h4040, 1'b1, 9'h081, 16'h6000, 1'b0};
    tbl[3]  = '{16'h7F00, 16'h7F00, 1'b0, 9'h100, 16'h4000, 1'b1};
    tbl[4]  = '{16'h0080, 16'h0080, 1'b0, 9'h000, 16'h0000, 1'b1};
    tbl[5]  = '{16'h7F80, 16'h3F80, 1'b0, 9'h0FF, 16'h4000, 1'b1};
    tbl[6]  = '{16'h0000, 16'h3F80, 1'b0, 9'h000, 16'h0000, 1'b1};
    tbl[7]  = '{16'h8000, 16'h3F80, 1'b1, 9'h000, 16'h0000, 1'b1};
    tbl[8]  = '{16'h3FFF, 16'h3FFF, 1'b0, 9'h07F, 16'hFE01, 1'b0};
    tbl[9]  = '{16'hBF80, 16'hBF80, 1'b0, 9'h07F, 16'h4000, 1'b0};
    tbl[10] = '{16'h2000, 16'h2000, 1'b0, 9'h001, 16'h4000, 1'b0};
    tbl[11] = '{16'h2000, 16'h1F80, 1'b0, 9'h000, 16'h0000, 1'b1};
    tbl[12] = '{16'h7F00, 16'h4000, 1'b0, 9'h0FF, 16'h4000, 1'b0};
    tbl[13] = '{16'h7F00, 16'h4080, 1'b0, 9'h100, 16'h4000, 1'b1};
    tbl[14] = '{16'hFFC1, 16'h3F80, 1'b1, 9'h0FF, 16'h4000, 1'b1};
    tbl[15] = '{16'h3FA0, 16'hC0E0, 1'b1, 9'h081, 16'h8C00, 1'b0};

    #1;
    chk("rst_in_ready1", 32'(in_ready1), 32'd1);
    chk("rst_out_valid1", 32'(out_valid1), 32'd0);
    chk("rst_sign1", 32'(sign1), 32'd0);
    chk("rst_exp1", 32'(exp1), 32'd0);
    chk("rst_mant1", 32'(mant1), 32'd0);
    chk("rst_out_valid4", 32'(out_valid4), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) run_vec(i, tbl[i]);

    // Backpressure: hold result for 5 cycles while a second request is offered
    @(negedge clk);
    a_in = 16'h3FC0;
    b_in = 16'h3FC0;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int c = 0; c < 20 && !out_valid1; c++) @(posedge clk);
    #1;
    chk("bp_valid_seen", 32'(out_valid1), 32'd1);
    @(negedge clk);
    a_in = 16'h4040;
    b_in = 16'h4040;
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("bp%0d_valid", c), 32'(out_valid1), 32'd1);
      chk($sformatf("bp%0d_mant", c), 32'(mant1), 32'h9000);
      chk($sformatf("bp%0d_exp", c), 32'(exp1), 32'h07F);
      chk($sformatf("bp%0d_in_ready", c), 32'(in_ready1), 32'd0);
      chk($sformatf("bp%0d_mant4", c), 32'(mant4), 32'h9000);
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("bp_release_valid", 32'(out_valid1), 32'd0);
    chk("bp_release_in_ready", 32'(in_ready1), 32'd1);
    repeat (10) @(posedge clk);
    #1;
    chk("bp_no_accept_valid", 32'(out_valid1), 32'd0);
    chk("bp_no_accept_in_ready", 32'(in_ready1), 32'd1);

    // Reset pulse in the middle of CALC
    @(negedge clk);
    a_in = 16'h3FC0;
    b_in = 16'h3FC0;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("mid_busy_in_ready1", 32'(in_ready1), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid1", 32'(out_valid1), 32'd0);
    chk("mid_rst_in_ready1", 32'(in_ready1), 32'd1);
    chk("mid_rst_in_ready4", 32'(in_ready4), 32'd1);
    chk("mid_rst_mant1", 32'(mant1), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk("post_rst_valid1", 32'(out_valid1), 32'd0);
    chk("post_rst_valid4", 32'(out_valid4), 32'd0);
    chk("post_rst_in_ready1", 32'(in_ready1), 32'd1);

    run_vec(100, tbl[2]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
